mvm_layer_ctrl: RTL and testbench
=================================

MVM_LAYER_CTRL -- requirements
Module: mvm_layer_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- M, 32, output rows per vector.
- N, 64, input values per vector.
- P, 4, parallel MAC lanes.
- M SHALL be divisible by P.
- Derived widths: XA=max(1,$clog2(N)), WA=max(1,$clog2(M/P*N)), LS=max(1,$clog2(P)).
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- s_valid_x  in  1  upstream value valid.
- s_ready_x  out  1  controller accepts input.
- m_valid_y  out  1  output value valid.
- m_ready_y  in  1  downstream accepts output.
- x_wr_en  out  1  write accepted x into vector memory.
- x_addr  out  XA  vector memory address (write in LOAD, read in ADDR).
- w_addr  out  WA  weight ROM address, common to all lanes.
- acc_en  out  1  lanes accumulate this cycle.
- acc_first  out  1  with acc_en: load product instead of add.
- out_sel  out  LS  lane driven to m_data_out_y by datapath mux.

Function
REQ-003 States SHALL be LOAD, ADDR, FLUSH, OUT.
REQ-004 Counters SHALL be: k (0..N-1), g (group, 0..M/P-1), lane (0..P-1).
REQ-005 s_ready_x SHALL be combinational: 1 iff state==LOAD.
REQ-006 m_valid_y SHALL be combinational: 1 iff state==OUT.
REQ-007 LOAD: on s_valid_x&&s_ready_x, x_wr_en=1 that cycle with x_addr=k, then k increments.
REQ-008 LOAD: s_valid_x=0 SHALL leave k unchanged and x_wr_en=0.
REQ-009 LOAD: accept with k==N-1 SHALL set k=0 and go to ADDR next cycle.
REQ-010 ADDR: each cycle x_addr=k, w_addr=g*N+k, k increments; at k==N-1, k=0 and next state FLUSH.
REQ-011 acc_en SHALL be a 1-cycle-delayed register of (state==ADDR).
REQ-012 acc_first SHALL be a 1-cycle-delayed register of (state==ADDR && k==0), matching 1-cycle memory read latency.
REQ-013 FLUSH SHALL last exactly one cycle (last acc_en occurs here), then go to OUT with lane=0.
REQ-014 OUT: out_sel=lane; on m_valid_y&&m_ready_y with lane<P-1, lane increments.
REQ-015 OUT: on handshake with lane==P-1, lane=0; if g<M/P-1 then g increments and next state ADDR, else g=0 and next state LOAD.
REQ-016 OUT: m_ready_y=0 SHALL hold state, lane, out_sel; no address or acc activity in OUT.
REQ-017 Signals in LOAD/OUT SHALL ignore the opposite-side handshake (m_ready_y in LOAD, s_valid_x in OUT).
REQ-018 x_wr_en and acc_en SHALL never both be 1.
REQ-019 Outside their active states: x_wr_en=0; x_addr, w_addr, out_sel SHALL be 0.
REQ-020 Group latency SHALL be N+1 cycles from first ADDR cycle to first OUT cycle.
REQ-021 Throughput with always-valid/always-ready SHALL be N + (M/P)*(N+1+P) cycles per vector.
REQ-022 Edge cases SHALL work without special handling:
- N=1: ADDR lasts one cycle.
- M/P=1: OUT returns straight to LOAD.
- P=1: one output per group.

Reset
REQ-023 reset sampled high SHALL, on that edge, force state=LOAD and k=g=lane=0.
REQ-024 The same edge SHALL clear the acc_en/acc_first pipeline registers.
REQ-025 Reset SHALL take effect from any state, mid-load or mid-compute.
REQ-026 Partially loaded or accumulated data SHALL be abandoned on reset.
REQ-027 During and after reset:
- s_ready_x=1, m_valid_y=0, x_wr_en=0, acc_en=0, acc_first=0.
- x_addr=0, w_addr=0, out_sel=0.

Verification (M=4, N=3, P=2)
REQ-028 Reset, then idle cycles -> s_ready_x=1, m_valid_y=0, acc_en=0, all addresses 0.
REQ-029 s_valid_x pattern 1,0,1,1 -> x_wr_en on cycles 0,2,3 with x_addr 0,1,2; s_ready_x=0 from cycle 4.
REQ-030 Group 0 ADDR at cycles t..t+2 -> w_addr 0,1,2 and x_addr 0,1,2.
- acc_en high t+1..t+3; acc_first high only at t+1.
- m_valid_y rises at t+4 with out_sel=0.
REQ-031 m_ready_y held 0 for 5 cycles in OUT -> m_valid_y stays 1, out_sel stays 0, acc_en=0, w_addr stable.
REQ-032 Full vector with m_ready_y=1 -> outputs carry out_sel 0,1,0,1; group 1 w_addr 3,4,5; s_ready_x=1 the cycle after the 4th handshake.
REQ-033 reset pulsed during group-1 ADDR -> next cycle LOAD, acc_en=0; a following 3-value load restarts at x_addr 0 and group 0.

Source files
------------

// File: rtl/mvm_layer_ctrl.sv
// mvm_layer_ctrl: sequencing controller for a P-lane matrix-vector layer.
// Loads an N-value input vector into vector memory, then for each of M/P
// row groups streams N vector/weight addresses to the MAC lanes, waits one
// flush cycle for the memory read latency, and presents the P lane results
// one by one on the output handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   s_valid_x  upstream value valid
//   s_ready_x  controller accepts input (high in LOAD)
//   m_valid_y  output value valid (high in OUT)
//   m_ready_y  downstream accepts output
//   x_wr_en    write the accepted value into vector memory
//   x_addr     vector memory address (write in LOAD, read in ADDR)
//   w_addr     weight ROM address shared by all lanes
//   acc_en     lanes accumulate this cycle
//   acc_first  with acc_en: load the product instead of adding
//   out_sel    lane routed to the output by the datapath mux
//
// M must be a multiple of P.
module mvm_layer_ctrl #(
  parameter int unsigned M = 32,
  parameter int unsigned N = 64,
  parameter int unsigned P = 4,
  localparam int unsigned XA = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned WA = ((M / P) * N > 1) ? $clog2((M / P) * N) : 1,
  localparam int unsigned LS = (P > 1) ? $clog2(P) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid_x,
  output logic          s_ready_x,
  output logic          m_valid_y,
  input  logic          m_ready_y,
  output logic          x_wr_en,
  output logic [XA-1:0] x_addr,
  output logic [WA-1:0] w_addr,
  output logic          acc_en,
  output logic          acc_first,
  output logic [LS-1:0] out_sel
);

  localparam int unsigned G  = M / P;
  localparam int unsigned GA = (G > 1) ? $clog2(G) : 1;

  localparam logic [XA-1:0] KMAX = XA'(N - 1);
  localparam logic [GA-1:0] GMAX = GA'(G - 1);
  localparam logic [LS-1:0] LMAX = LS'(P - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ADDR  = 2'd1,
    FLUSH = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t        state;
  logic [XA-1:0] k;
  logic [GA-1:0] g;
  logic [LS-1:0] lane;

  // Sequencer: state, counters and the accumulate-control pipeline that
  // lines acc_en/acc_first up with the one-cycle memory read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      k         <= '0;
      g         <= '0;
      lane      <= '0;
      acc_en    <= 1'b0;
      acc_first <= 1'b0;
    end else begin
      acc_en    <= (state == ADDR);
      acc_first <= (state == ADDR) && (k == '0);
      case (state)
        LOAD: begin
          if (s_valid_x) begin
            if (k == KMAX) begin
              k     <= '0;
              state <= ADDR;
            end else begin
              k <= k + XA'(1);
            end
          end
        end
        ADDR: begin
          if (k == KMAX) begin
            k     <= '0;
            state <= FLUSH;
          end else begin
            k <= k + XA'(1);
          end
        end
        FLUSH: begin
          lane  <= '0;
          state <= OUT;
        end
        OUT: begin
          if (m_ready_y) begin
            if (lane == LMAX) begin
              lane <= '0;
              if (g == GMAX) begin
                g     <= '0;
                state <= LOAD;
              end else begin
                g     <= g + GA'(1);
                state <= ADDR;
              end
            end else begin
              lane <= lane + LS'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Handshakes, memory addresses and output select follow the current state;
  // everything idles at zero outside the state that uses it.
  always_comb begin
    s_ready_x = (state == LOAD);
    m_valid_y = (state == OUT);
    x_wr_en   = (state == LOAD) && s_valid_x;
    x_addr    = '0;
    w_addr    = '0;
    out_sel   = '0;
    if (state == LOAD || state == ADDR) x_addr = k;
    if (state == ADDR) w_addr = WA'(32'(g) * N + 32'(k));
    if (state == OUT) out_sel = lane;
  end

endmodule

// File: tb/tb_mvm_layer_ctrl.sv
// Bench for mvm_layer_ctrl with M=4, N=3, P=2. A schedule-position model
// predicts every output each cycle; directed sequences pin literal values.
module tb_mvm_layer_ctrl;

  localparam int unsigned M   = 4;
  localparam int unsigned N   = 3;
  localparam int unsigned P   = 2;
  localparam int unsigned G   = M / P;
  localparam int unsigned PER = N + 1 + P;
  localparam int unsigned VEC = N + G * PER;
  localparam int unsigned XA  = 2;
  localparam int unsigned WA  = 3;
  localparam int unsigned LS  = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid_x = 1'b0;
  logic          m_ready_y = 1'b0;
  logic          s_ready_x, m_valid_y, x_wr_en, acc_en, acc_first;
  logic [XA-1:0] x_addr;
  logic [WA-1:0] w_addr;
  logic [LS-1:0] out_sel;

  int n_cmp = 0;
  int n_bad = 0;

  mvm_layer_ctrl #(.M(M), .N(N), .P(P)) dut (
    .clk(clk), .reset(reset),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
    .x_wr_en(x_wr_en), .x_addr(x_addr), .w_addr(w_addr),
    .acc_en(acc_en), .acc_first(acc_first), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Position within one vector's fixed schedule: N load slots, then per group
  // N address slots, one flush slot and P output slots. ph: 0 load, 1 addr,
  // 2 flush, 3 out.
  function automatic void decode(input int p, output int ph, output int k,
                                 output int g, output int lane);
    int r;
    ph = 0; k = 0; g = 0; lane = 0;
    if (p < int'(N)) begin
      k = p;
    end else begin
      r = p - int'(N);
      g = r / int'(PER);
      r = r % int'(PER);
      if (r < int'(N)) begin
        ph = 1; k = r;
      end else if (r == int'(N)) begin
        ph = 2;
      end else begin
        ph = 3; lane = r - int'(N) - 1;
      end
    end
  endfunction

  int pos = 0;
  bit prev_addr = 1'b0;
  bit prev_first = 1'b0;
  bit model_on = 1'b0;

  // Model advance: load slots wait on s_valid_x, output slots on m_ready_y.
  always @(posedge clk) begin
    int ph, k, g, lane;
    bit adv;
    if (reset) begin
      pos = 0; prev_addr = 1'b0; prev_first = 1'b0; model_on = 1'b1;
    end else if (model_on) begin
      decode(pos, ph, k, g, lane);
      prev_addr  = (ph == 1);
      prev_first = (ph == 1) && (k == 0);
      adv = (ph == 0) ? s_valid_x : (ph == 3) ? m_ready_y : 1'b1;
      if (adv) pos = (pos + 1) % int'(VEC);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int ph, k, g, lane;
    if (model_on) begin
      decode(pos, ph, k, g, lane);
      check("m_s_ready", int'(s_ready_x), int'(ph == 0));
      check("m_m_valid", int'(m_valid_y), int'(ph == 3));
      check("m_x_wr_en", int'(x_wr_en), int'(ph == 0 && s_valid_x));
      check("m_x_addr", int'(x_addr), (ph <= 1) ? k : 0);
      check("m_w_addr", int'(w_addr), (ph == 1) ? g * int'(N) + k : 0);
      check("m_out_sel", int'(out_sel), (ph == 3) ? lane : 0);
      check("m_acc_en", int'(acc_en), int'(prev_addr));
      check("m_acc_first", int'(acc_first), int'(prev_first));
      check("m_wr_acc_excl", int'(x_wr_en && acc_en), 0);
    end
  end

  task automatic cyc(input bit sv, input bit mr, input bit rs);
    @(posedge clk);
    #1;
    reset = rs; s_valid_x = sv; m_ready_y = mr;
    @(negedge clk);
  endtask

  initial begin
    bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int ea, cnt;
    bit prev_rdy;

    cyc(0, 0, 1); cyc(0, 0, 1);
    repeat (3) begin
      cyc(0, 0, 0);
      check("idle_s_ready", int'(s_ready_x), 1);
      check("idle_m_valid", int'(m_valid_y), 0);
      check("idle_acc_en", int'(acc_en), 0);
      check("idle_w_addr", int'(w_addr), 0);
      check("idle_out_sel", int'(out_sel), 0);
    end

    ea = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(pat[i], 0, 0);
      check("load_wr", int'(x_wr_en), int'(pat[i]));
      if (pat[i]) begin
        check("load_x_addr", int'(x_addr), ea);
        ea++;
      end
    end

    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      check("g0_s_ready", int'(s_ready_x), 0);
      check("g0_w_addr", int'(w_addr), i);
      check("g0_x_addr", int'(x_addr), i);
      check("g0_acc_en", int'(acc_en), int'(i > 0));
      check("g0_acc_first", int'(acc_first), int'(i == 1));
    end
    cyc(0, 0, 0);
    check("flush_acc_en", int'(acc_en), 1);
    check("flush_acc_first", int'(acc_first), 0);
    check("flush_m_valid", int'(m_valid_y), 0);
    cyc(0, 0, 0);
    check("out_m_valid", int'(m_valid_y), 1);
    check("out_sel0", int'(out_sel), 0);
    check("out_acc_en", int'(acc_en), 0);
    repeat (4) begin
      cyc(0, 0, 0);
      check("stall_m_valid", int'(m_valid_y), 1);
      check("stall_out_sel", int'(out_sel), 0);
      check("stall_acc_en", int'(acc_en), 0);
      check("stall_w_addr", int'(w_addr), 0);
    end
    cyc(0, 1, 0); check("hs0_out_sel", int'(out_sel), 0);
    cyc(0, 1, 0); check("hs1_out_sel", int'(out_sel), 1);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0);
      check("g1_w_addr", int'(w_addr), 3 + i);
      check("g1_x_addr", int'(x_addr), i);
    end
    cyc(0, 1, 0);
    cyc(0, 1, 0); check("g1_out_sel0", int'(out_sel), 0);
    cyc(0, 1, 0); check("g1_out_sel1", int'(out_sel), 1);
    cyc(0, 1, 0);
    check("reload_s_ready", int'(s_ready_x), 1);
    check("reload_m_valid", int'(m_valid_y), 0);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0);
      check("l2_x_addr", int'(x_addr), i);
    end
    repeat (6) cyc(0, 1, 0);
    cyc(0, 1, 0); check("g1b_w_addr", int'(w_addr), 3);
    cyc(0, 1, 1); check("rst_cycle_w_addr", int'(w_addr), 4);
    cyc(0, 1, 0);
    check("post_rst_s_ready", int'(s_ready_x), 1);
    check("post_rst_acc_en", int'(acc_en), 0);
    check("post_rst_m_valid", int'(m_valid_y), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0);
      check("l3_x_addr", int'(x_addr), i);
    end
    cyc(0, 1, 0);
    check("l3_g0_w_addr", int'(w_addr), 0);

    // Vector period with continuous valid/ready: 3 + 2*(3+1+2) = 15 cycles.
    cnt = 0;
    while (!s_ready_x && cnt < 50) begin
      cyc(1, 1, 0);
      cnt++;
    end
    check("period_reach_load", int'(s_ready_x), 1);
    cnt = 1; prev_rdy = s_ready_x;
    cyc(1, 1, 0);
    while (!(s_ready_x && !prev_rdy) && cnt < 50) begin
      prev_rdy = s_ready_x;
      cyc(1, 1, 0);
      cnt++;
    end
    check("vector_period", cnt, 15);

    repeat (3000) begin
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 199) == 0));
    end
    cyc(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
